// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   Return path of the CPU memory bus. Takes the address decoder's device
//   selects and each device's read data, times the access for the selected
//   device class, and returns a one-cycle ready pulse plus registered data.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   : flash accesses give up after TIMEOUT_CYCLES cycles in
//               FLASH_WAIT, returning 32'hDEADBEEF with a bus_error pulse.
//   Undefined : flash accesses wait indefinitely, bus_error is tied low.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-low reset
//   cpu_mem_valid    CPU request valid
//   cpu_wstrb        CPU byte write strobes (0 = read)
//   *_en             decoder device selects
//   *_rdata/_data    device read data
//   flash_read_ready flash controller data-valid strobe
//   cpu_mem_ready    transfer complete, one-cycle pulse
//   cpu_mem_rdata    registered read data, held between transfers
//   bus_error        one-cycle pulse with a timed-out flash ack
module cpu_bus_responder #(
    parameter int unsigned RAM_LATENCY    = 1,
    parameter int unsigned VDP_LATENCY    = 2,
    parameter int unsigned REG_LATENCY    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_valid,
    input  logic [3:0]  cpu_wstrb,
    input  logic        cpu_ram_en,
    input  logic        vdp_en,
    input  logic        status_en,
    input  logic        dsp_en,
    input  logic        pad_en,
    input  logic        flash_read_en,
    input  logic [31:0] cpu_ram_rdata,
    input  logic [31:0] vdp_rdata,
    input  logic [31:0] status_rdata,
    input  logic [31:0] dsp_rdata,
    input  logic [31:0] pad_rdata,
    input  logic [31:0] flash_read_data,
    input  logic        flash_read_ready,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FLASH_WAIT,
        ST_ACK
    } state_t;

    typedef enum logic [2:0] {
        DEV_NONE,
        DEV_RAM,
        DEV_VDP,
        DEV_STATUS,
        DEV_DSP,
        DEV_PAD
    } dev_t;

    localparam int unsigned MAX_RV  = (RAM_LATENCY > VDP_LATENCY) ? RAM_LATENCY : VDP_LATENCY;
    localparam int unsigned MAX_LAT = (MAX_RV > REG_LATENCY) ? MAX_RV : REG_LATENCY;
    // The counter is loaded with at most MAX_LAT-2.
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;

    state_t           state;
    dev_t             dev_q;
    dev_t             dec_dev;
    dev_t             mux_dev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dec_load;
    int unsigned      dec_lat;
    logic [31:0]      mux_data;
    // Cleared by an ACK that still sees valid high; set once valid is seen low.
    logic             armed;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // Fixed-latency device decode; flash is handled ahead of this in the FSM.
    always_comb begin
        dec_dev = DEV_NONE;
        if (cpu_ram_en)     dec_dev = DEV_RAM;
        else if (vdp_en)    dec_dev = DEV_VDP;
        else if (status_en) dec_dev = DEV_STATUS;
        else if (dsp_en)    dec_dev = DEV_DSP;
        else if (pad_en)    dec_dev = DEV_PAD;
    end

    always_comb begin
        dec_lat = 1;
        case (dec_dev)
            DEV_RAM:                     dec_lat = RAM_LATENCY;
            DEV_VDP:                     dec_lat = VDP_LATENCY;
            DEV_STATUS, DEV_DSP, DEV_PAD: dec_lat = REG_LATENCY;
            default:                     dec_lat = 1;
        endcase
        dec_load = CNT_W'(dec_lat - 2);
    end

    // One data mux: the live decode in IDLE, the latched select in WAIT.
    always_comb begin
        mux_dev  = (state == ST_IDLE) ? dec_dev : dev_q;
        mux_data = '0;
        case (mux_dev)
            DEV_RAM:    mux_data = cpu_ram_rdata;
            DEV_VDP:    mux_data = vdp_rdata;
            DEV_STATUS: mux_data = status_rdata;
            DEV_DSP:    mux_data = dsp_rdata;
            DEV_PAD:    mux_data = pad_rdata;
            default:    mux_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            dev_q         <= DEV_NONE;
            cnt           <= '0;
            armed         <= 1'b1;
            cpu_mem_ready <= 1'b0;
            cpu_mem_rdata <= '0;
            bus_error     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            cpu_mem_ready <= 1'b0;
            bus_error     <= 1'b0;
            if (!cpu_mem_valid) armed <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cpu_mem_valid && armed) begin
                        if (flash_read_en) begin
                            if (cpu_wstrb != '0) begin
                                cpu_mem_rdata <= '0;
                                cpu_mem_ready <= 1'b1;
                                state         <= ST_ACK;
                            end else begin
                                state <= ST_FLASH_WAIT;
`ifdef BUS_TIMEOUT_EN
                                tmo_cnt <= '0;
`endif
                            end
                        end else if (dec_dev == DEV_NONE) begin
                            cpu_mem_rdata <= '0;
                            cpu_mem_ready <= 1'b1;
                            state         <= ST_ACK;
                        end else if (dec_lat <= 1) begin
                            cpu_mem_rdata <= mux_data;
                            cpu_mem_ready <= 1'b1;
                            state         <= ST_ACK;
                        end else begin
                            dev_q <= dec_dev;
                            cnt   <= dec_load;
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!cpu_mem_valid) begin
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        cpu_mem_rdata <= mux_data;
                        cpu_mem_ready <= 1'b1;
                        state         <= ST_ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_FLASH_WAIT: begin
                    if (!cpu_mem_valid) begin
                        state <= ST_IDLE;
                    end else if (flash_read_ready) begin
                        cpu_mem_rdata <= flash_read_data;
                        cpu_mem_ready <= 1'b1;
                        state         <= ST_ACK;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        cpu_mem_rdata <= 32'hDEADBEEF;
                        cpu_mem_ready <= 1'b1;
                        bus_error     <= 1'b1;
                        state         <= ST_ACK;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                ST_ACK: begin
                    armed <= !cpu_mem_valid;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Return path of the CPU memory bus; pairs with the address decoder.
- Takes the decoder's one-hot device enables and each device's read data.
- Times each access per device class. Returns a one-cycle `cpu_mem_ready` pulse and a registered `cpu_mem_rdata` to the CPU.
- Sits between the CPU and the peripheral/RAM/flash read muxing.

Parameters:
- RAM_LATENCY, 1, cycles from first valid cycle to ready for CPU RAM (>=1)
- VDP_LATENCY, 2, same, for VDP accesses (>=1)
- REG_LATENCY, 1, same, for status/DSP/pad accesses (>=1)
- TIMEOUT_CYCLES, 255, flash wait limit (used only with BUS_TIMEOUT_EN)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (0 = in reset)
- cpu_mem_valid  input  1  CPU request valid
- cpu_wstrb  input  4  CPU byte write strobes (0 = read)
- cpu_ram_en, vdp_en, status_en, dsp_en, pad_en, flash_read_en  input  1 each  decoder selects
- cpu_ram_rdata, vdp_rdata, status_rdata, dsp_rdata, pad_rdata, flash_read_data  input  32 each  device read data
- flash_read_ready  input  1  flash controller data-valid strobe
- cpu_mem_ready  output  1  transfer complete, one-cycle pulse
- cpu_mem_rdata  output  32  registered read data
- bus_error  output  1  one-cycle pulse on timeout (tied 0 without BUS_TIMEOUT_EN)

Behaviour:
- Reset (reset low at a clk edge): state IDLE, `cpu_mem_ready`=0, `cpu_mem_rdata`=0, `bus_error`=0, counters 0. Reset overrides any in-flight access; no ready is issued for it.
- Cycle numbering: cycle 0 = first cycle in IDLE with `cpu_mem_valid`=1. For fixed-latency devices, `cpu_mem_ready` is high in cycle L. `cpu_mem_rdata` is loaded from the selected device at the edge ending cycle L-1.
- Device select is latched at the end of cycle 0. Priority if more than one enable is set: flash > ram > vdp > status > dsp > pad.
- States: IDLE, WAIT, FLASH_WAIT, ACK.
- IDLE, valid with fixed-latency select:
  - L=1: sample data, go to ACK.
  - L>1: load counter with L-2, go to WAIT.
- WAIT: counter decrements each cycle. At 0, sample selected data and go to ACK.
- IDLE, valid with `flash_read_en`:
  - Read: go to FLASH_WAIT.
  - Write (`wstrb`!=0): no flash action, rdata loaded with 0, go to ACK (L=1).
- FLASH_WAIT: on `flash_read_ready`=1, sample `flash_read_data` and go to ACK. Ready is therefore high one cycle after `flash_read_ready`.
- IDLE, valid with no select (unmapped): rdata <= 0, go to ACK.
- ACK: `cpu_mem_ready`=1 for exactly this cycle, then IDLE.
  - The initiator drops valid in the cycle after ready.
  - IDLE does not re-arm until valid has been sampled low at least once after ACK; back-to-back requests need one idle cycle.
- Writes use the same latency as reads for their device. rdata is still updated with the device's data bus, and software ignores it.
- `cpu_mem_valid` dropping in WAIT/FLASH_WAIT: abort, return to IDLE, no ready, rdata unchanged.
- `cpu_mem_rdata` holds its value between transfers.
- The counter is width-sized to max(latencies) and never wraps.

Optional Feature:
- Macro `BUS_TIMEOUT_EN`.
- Defined: FLASH_WAIT counts cycles. If `flash_read_ready` has not arrived after TIMEOUT_CYCLES cycles in FLASH_WAIT:
  - `cpu_mem_rdata` <= 32'hDEADBEEF
  - go to ACK
  - `bus_error`=1 in the ACK cycle

  A ready arriving in the same cycle as expiry wins (real data, no error).
- Undefined: FLASH_WAIT waits indefinitely, `bus_error` is constant 0, no timeout counter is synthesized.

Test Plan:
- RAM read, `cpu_ram_rdata`=32'h12345678, RAM_LATENCY=1: valid at cycle 0 -> ready=1 only in cycle 1, rdata=32'h12345678; next read needs valid low for one cycle.
- VDP write, `wstrb`=4'hF, VDP_LATENCY=2: ready=1 in cycle 2 only; read with `vdp_rdata`=32'h0000ABCD -> rdata=32'h0000ABCD in cycle 2.
- Flash read, `flash_read_ready` pulsed in cycle 7 with data 32'hCAFEF00D -> ready=1 in cycle 8, rdata=32'hCAFEF00D, `bus_error`=0.
- Reset low during WAIT of a VDP access (VDP_LATENCY=4, reset in cycle 2) -> no ready ever, rdata=0, state IDLE; fresh status read afterwards acks at L=1.
- Valid dropped in cycle 1 of a 4-cycle VDP read -> no ready; next pad read (`pad_rdata`=32'h5) acks in cycle 1 with 32'h5.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, flash never ready -> ready=1 and `bus_error`=1 together one cycle after the 16th FLASH_WAIT cycle, rdata=32'hDEADBEEF.
